riscv_multicycle_controller: RTL
================================

# riscv_multicycle_controller

Moore/Mealy control FSM that sequences the team's multicycle RISC-V datapath (shared instruction/data memory, IR/OldPC/MDR/A/B/ALUOut registers). Consumes the decoded instruction fields and ALU flags from the datapath; drives every register enable, mux select, ALU opcode and immediate-format select. One instruction in flight; CPI 2–5 by class.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- Opcode  in  7  instr[6:0] from IR.
- Func3  in  3  instr[14:12].
- Func7  in  1  instr[30].
- ZeroFlag, NegFlag  in  1 each  from combinational ALU result.
- PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  write enables.
- AdrSlc  out  1  0=PC, 1=Result.
- InputA  out  2  0=PC, 1=OldPC, 2=A.
- InputB  out  2  0=B, 1=ImmExt, 2=const 4.
- ResultSlc  out  2  0=ALUOut, 1=MDR, 2=ALUResult, 3=ImmExt.
- AluOpcode  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
- ImmSlc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- InstrDone  out  1  one-cycle pulse in final state of each legal instruction.
- IllegalInstr  out  1  one-cycle pulse in DECODE for unsupported encoding.

## Operation
- Unlisted outputs are 0 in every state.
- FETCH: AdrSlc=0, IRWrite=1, InputA=0, InputB=2, add, ResultSlc=2, PCWrite=1 (PC<=PC+4, OldPC<=PC). -> DECODE.
- DECODE: InputA=1, InputB=1, ImmSlc=B, add (ALUOut<=branch target). Next by Opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXR; 0010011 -> EXI; 1100011 -> BRANCH; 1101111 -> JAL1; 1100111 -> JALR1; 0110111 -> LUI; else IllegalInstr=1, -> FETCH.
- Legal funct: R: 000 add (Func7=0)/sub (Func7=1), 111 and, 110 or, 010 slt, 100 xor. I: same minus sub, Func7 ignored. Branch Func3: 000 beq, 001 bne, 100 blt, 101 bge. Any other funct -> illegal path.
- MEMADR: InputA=2, InputB=1, add, ImmSlc=I (lw) or S (sw). -> MEMRD (lw) / MEMWR (sw).
- MEMRD: AdrSlc=1, ResultSlc=0. -> MEMWB. MEMWB: ResultSlc=1, RegWrite=1, InstrDone. -> FETCH.
- MEMWR: AdrSlc=1, ResultSlc=0, MemWrite=1, InstrDone. -> FETCH.
- EXR: InputA=2, InputB=0, AluOpcode per funct. EXI: InputA=2, InputB=1, ImmSlc=I, AluOpcode per funct. Both -> ALUWB: ResultSlc=0, RegWrite=1, InstrDone. -> FETCH.
- BRANCH: InputA=2, InputB=0, sub, ResultSlc=0; PCWrite = Zero (beq), !Zero (bne), Neg (blt), !Neg (bge) — combinational on flags; InstrDone. -> FETCH.
- JAL1: InputA=1, InputB=2, add, ResultSlc=2, RegWrite=1 (rd<=OldPC+4). JAL2: InputA=1, InputB=1, ImmSlc=J, add, ResultSlc=2, PCWrite=1, InstrDone. -> FETCH.
- JALR1: InputA=2, InputB=1, ImmSlc=I, add. JALR2: ResultSlc=0, PCWrite=1 (target taken before rd write so rd==rs1 is safe; LSB not masked). JALR3: InputA=1, InputB=2, add, ResultSlc=2, RegWrite=1, InstrDone. -> FETCH.
- LUI: ImmSlc=U, ResultSlc=3, RegWrite=1, InstrDone. -> FETCH.

## Timing
- rst=0: state forced to FETCH asynchronously; all outputs 0 (including FETCH enables) while rst=0. First FETCH outputs in the cycle rst is sampled 1.
- Cycles per instruction: R/I-ALU 4, lw 5, sw 4, branch 3, jal 4, jalr 5, lui 3, illegal 2.
- Outputs are combinational from state (plus Func fields, flags in BRANCH); no output registers. Opcode/Func must be stable from DECODE onward (IRWrite only in FETCH).
- NegFlag used as signed compare; overflow not corrected (documented limitation).
- rst asserted mid-instruction: instruction abandoned, no further enables; partial register writes already committed remain.
- Encoded state register 4 bits; unreachable codes -> FETCH.

## Test plan
- Reset: hold rst=0 3 cycles -> all outputs 0; release -> FETCH with IRWrite=PCWrite=1, InputB=2, ResultSlc=2.
- add x3,x1,x2 (0x002081B3) -> states FETCH,DECODE,EXR(AluOpcode=000,InputB=0),ALUWB(RegWrite=1,InstrDone=1); 4 cycles; sub (Func7=1) gives AluOpcode=001.
- lw x5,8(x1) then sw x5,12(x1) -> lw: MEMRD AdrSlc=1, MEMWB ResultSlc=1 RegWrite=1, 5 cycles; sw: MEMWR MemWrite=1, ImmSlc=S, 4 cycles.
- beq with ZeroFlag=1 -> PCWrite=1 in BRANCH; ZeroFlag=0 -> PCWrite=0; bge with NegFlag=0 -> PCWrite=1; 3 cycles each.
- jal / jalr x1,0(x1) -> jal RegWrite in JAL1 then PCWrite in JAL2; jalr PCWrite in JALR2 precedes RegWrite in JALR3.
- Opcode 0x7F and R-type Func3=001 -> IllegalInstr=1 in DECODE, no write enables, back to FETCH after 2 cycles; rst pulled low during MEMRD -> outputs 0 immediately.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// Control FSM for the multicycle RISC-V datapath: sequences register enables, mux selects and ALU op per instruction class.
// Latency: outputs are combinational from state (plus funct/flags); CPI 2 (illegal) to 5 (lw, jalr).
// Backpressure: none; one instruction in flight, shared memory assumed single-cycle.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] Func3,
  input  logic       Func7,
  input  logic       ZeroFlag,
  input  logic       NegFlag,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSlc,
  output logic [1:0] InputA,
  output logic [1:0] InputB,
  output logic [1:0] ResultSlc,
  output logic [2:0] AluOpcode,
  output logic [2:0] ImmSlc,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXR    = 4'd6,
    S_EXI    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL1   = 4'd10,
    S_JAL2   = 4'd11,
    S_JALR1  = 4'd12,
    S_JALR2  = 4'd13,
    S_JALR3  = 4'd14,
    S_LUI    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t     state, state_nxt;
  logic [2:0] funct_alu;
  logic       alu_f3_ok;
  logic       r_ok, i_ok, br_ok;
  logic       br_taken;

  // Funct decode shared by EXR/EXI: ALU op and legality of Func3/Func7
  always_comb begin
    funct_alu = ALU_ADD;
    alu_f3_ok = 1'b1;
    case (Func3)
      3'b000:  funct_alu = (Opcode == OP_R && Func7) ? ALU_SUB : ALU_ADD;
      3'b111:  funct_alu = ALU_AND;
      3'b110:  funct_alu = ALU_OR;
      3'b010:  funct_alu = ALU_SLT;
      3'b100:  funct_alu = ALU_XOR;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  // Func7 only selects add/sub in R-type; set on any other R op it is unsupported
  assign r_ok  = alu_f3_ok && (Func3 == 3'b000 || !Func7);
  assign i_ok  = alu_f3_ok;
  assign br_ok = (Func3 == 3'b000) || (Func3 == 3'b001) ||
                 (Func3 == 3'b100) || (Func3 == 3'b101);

  // Branch condition from ALU flags of rs1-rs2; NegFlag taken as signed lt without overflow fixup
  always_comb begin
    br_taken = 1'b0;
    case (Func3)
      3'b000:  br_taken = ZeroFlag;
      3'b001:  br_taken = !ZeroFlag;
      3'b100:  br_taken = NegFlag;
      3'b101:  br_taken = !NegFlag;
      default: br_taken = 1'b0;
    endcase
  end

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next state and per-state outputs; everything is forced low while reset is held
  always_comb begin
    state_nxt    = S_FETCH;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    AdrSlc       = 1'b0;
    InputA       = 2'd0;
    InputB       = 2'd0;
    ResultSlc    = 2'd0;
    AluOpcode    = ALU_ADD;
    ImmSlc       = IMM_I;
    InstrDone    = 1'b0;
    IllegalInstr = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        InputB    = 2'd2;
        ResultSlc = 2'd2;
        PCWrite   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        InputA = 2'd1;
        InputB = 2'd1;
        ImmSlc = IMM_B;
        case (Opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = r_ok  ? S_EXR    : S_FETCH;
          OP_I:         state_nxt = i_ok  ? S_EXI    : S_FETCH;
          OP_BR:        state_nxt = br_ok ? S_BRANCH : S_FETCH;
          OP_JAL:       state_nxt = S_JAL1;
          OP_JALR:      state_nxt = S_JALR1;
          OP_LUI:       state_nxt = S_LUI;
          default:      state_nxt = S_FETCH;
        endcase
        IllegalInstr = (state_nxt == S_FETCH);
      end
      S_MEMADR: begin
        InputA    = 2'd2;
        InputB    = 2'd1;
        ImmSlc    = (Opcode == OP_SW) ? IMM_S : IMM_I;
        state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSlc    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSlc = 2'd1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        AdrSlc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_EXR: begin
        InputA    = 2'd2;
        AluOpcode = funct_alu;
        state_nxt = S_ALUWB;
      end
      S_EXI: begin
        InputA    = 2'd2;
        InputB    = 2'd1;
        AluOpcode = funct_alu;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        InputA    = 2'd2;
        AluOpcode = ALU_SUB;
        PCWrite   = br_taken;
        InstrDone = 1'b1;
      end
      S_JAL1: begin
        InputA    = 2'd1;
        InputB    = 2'd2;
        ResultSlc = 2'd2;
        RegWrite  = 1'b1;
        state_nxt = S_JAL2;
      end
      S_JAL2: begin
        InputA    = 2'd1;
        InputB    = 2'd1;
        ImmSlc    = IMM_J;
        ResultSlc = 2'd2;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      S_JALR1: begin
        InputA    = 2'd2;
        InputB    = 2'd1;
        state_nxt = S_JALR2;
      end
      // PC is loaded from ALUOut before rd is written, so rd==rs1 cannot corrupt the target
      S_JALR2: begin
        PCWrite   = 1'b1;
        state_nxt = S_JALR3;
      end
      S_JALR3: begin
        InputA    = 2'd1;
        InputB    = 2'd2;
        ResultSlc = 2'd2;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_LUI: begin
        ImmSlc    = IMM_U;
        ResultSlc = 2'd3;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (!rst) begin
      state_nxt    = S_FETCH;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      AdrSlc       = 1'b0;
      InputA       = 2'd0;
      InputB       = 2'd0;
      ResultSlc    = 2'd0;
      AluOpcode    = ALU_ADD;
      ImmSlc       = IMM_I;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule
